data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Parametrised RISC-V data memory: byte-addressed, byte/half/word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) selected by funct3.
- Adds a valid/ready request port, a configurable read-latency response pipeline, and misalignment/range error reporting.
- Adds a post-reset zero-fill sequencer.
- Sits between the execute stage and writeback in the processor datapath.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words; power of two, >= 4
READ_LATENCY, 1, cycles from request acceptance to resp_valid; legal range 1..4
ADDR_WIDTH, 32, width of the byte address port

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present this cycle
req_ready  out  1  block can accept a request (high only in RUN)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V access size/sign code
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data; byte/half taken from LSBs
resp_valid  out  1  one-cycle pulse per accepted request
resp_rdata  out  32  load result, extended per funct3; 0 for stores and errors
resp_err  out  1  valid with resp_valid; misaligned, out-of-range or illegal funct3
init_done  out  1  high once zero-fill has completed

Behaviour:
- Reset (async, rst=1):
  - FSM enters INIT and the fill counter clears to 0.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0.
  - Latency pipeline is flushed. The memory array is not reset directly.
- INIT:
  - Each cycle writes 0 to word[fill_cnt], then fill_cnt+1.
  - After writing word DEPTH_WORDS-1, go to RUN. INIT lasts exactly DEPTH_WORDS cycles after rst deasserts.
  - req_valid is ignored during INIT.
- RUN:
  - req_ready=1 and init_done=1, held until the next reset.
  - Acceptance is req_valid & req_ready. One request per cycle; back-to-back requests accepted every cycle.
  - No response backpressure.
- Address decode:
  - Word index = req_addr[2 +: log2(DEPTH_WORDS)]; byte lane = req_addr[1:0].
  - Out of range if req_addr >= 4*DEPTH_WORDS.
- Legal funct3:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is illegal.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]!=0.
- Error handling: any error produces resp_err=1 and resp_rdata=0. A store with an error writes nothing.
- Stores:
  - Written at the acceptance edge with per-byte enables. SB writes lane addr[1:0]; SH writes lanes {addr[1],0} and {addr[1],1}; SW writes all lanes.
  - Bytes outside the enabled lanes are unchanged.
- Loads:
  - Array read at the acceptance edge.
  - Selected byte/half is placed in LSBs. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Latency:
  - Every accepted request, load or store, erroring or not, yields exactly one resp_valid pulse.
  - If accepted at edge N, the response is visible after edge N+READ_LATENCY-1. For READ_LATENCY=1 it is visible the cycle after acceptance.
  - Responses return in request order.
  - Outside response cycles, resp_rdata=0 and resp_err=0.
- Ordering: a load accepted in the cycle after a store to the same word returns the new data. There is no same-cycle load/store, since there is one request per cycle.
- Reset mid-operation: in-flight responses are discarded with no resp_valid; INIT restarts from word 0.

Test Plan:
- Reset then idle: rst pulse -> req_ready=0 for 64 cycles, then req_ready=1 and init_done=1. LW of every address 0x00..0xFC returns 0x00000000 with resp_err=0.
- Sizes and sign: SW 0x0 data 0x8081_7F80, then:
  - LB 0x0 -> 0xFFFFFF80; LBU 0x0 -> 0x00000080; LB 0x1 -> 0x0000007F.
  - LH 0x2 -> 0xFFFF8081; LHU 0x2 -> 0x00008081.
- Partial stores: SW 0x10 data 0xFFFFFFFF; SB 0x12 data 0x00; SH 0x10 data 0x1234 -> LW 0x10 returns 0xFF001234.
- Errors:
  - LW 0x6 -> resp_err=1, rdata=0.
  - SH 0x3 data 0xAAAA -> resp_err=1 and word 0 unchanged.
  - LW 0x100 (out of range) -> resp_err=1.
  - funct3=011 -> resp_err=1.
- Pipeline, READ_LATENCY=3: 4 back-to-back LWs to 0x0, 0x4, 0x8, 0xC preloaded with 1, 2, 3, 4 -> resp_valid on 4 consecutive cycles. The first response is visible 3 cycles after the first accept, data in order 1, 2, 3, 4. A store followed immediately by a load of the same word returns the stored value.
- Reset mid-burst: assert rst while 2 responses are in flight -> no resp_valid appears, req_ready=0 for DEPTH_WORDS cycles, and previously stored words read back 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// RISC-V data memory: byte/half/word loads and stores behind a valid/ready port,
// with a fixed-latency response pipeline, error reporting and post-reset zero fill.

module data_mem_bank #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);
  logic [7:0] mem [2**IDX_W];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module data_mem_ctrl #(
  parameter int DEPTH_WORDS  = 64,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);
  localparam int IDX_W     = $clog2(DEPTH_WORDS);
  localparam int NUM_LANES = 4;

  typedef enum logic [0:0] {INIT, RUN} state_t;

  state_t                          state;
  logic [IDX_W-1:0]                fill_cnt;
  logic                            acc, oor, f3_ok, misal, err;
  logic [IDX_W-1:0]                idx;
  logic [1:0]                      lane;
  logic [NUM_LANES-1:0]            be;
  logic [NUM_LANES-1:0]            bank_we;
  logic [IDX_W-1:0]                bank_waddr;
  logic [NUM_LANES-1:0][7:0]       bank_wdata;
  logic [NUM_LANES-1:0][7:0]       rd_word;
  logic [31:0]                     word, ld_data;
  logic [7:0]                      byte_v;
  logic [15:0]                     half_v;

  logic [READ_LATENCY:1]           vld_pipe;
  logic [31:0]                     dat_pipe [READ_LATENCY:1];
  logic [READ_LATENCY:1]           err_pipe;

  // Request decode
  assign acc  = req_valid & req_ready;
  assign idx  = req_addr[2 +: IDX_W];
  assign lane = req_addr[1:0];
  assign oor  = |req_addr[ADDR_WIDTH-1:IDX_W+2];

  always_comb begin
    f3_ok = 1'b0;
    if (req_we) f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  end

  assign misal = ((req_funct3[1:0] == 2'b01) & lane[0]) |
                 ((req_funct3[1:0] == 2'b10) & (lane != 2'b00));
  assign err   = ~f3_ok | misal | oor;

  always_comb begin
    be = 4'b0000;
    case (req_funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // During INIT the fill sequencer owns every bank's write port
  assign bank_waddr = (state == INIT) ? fill_cnt : idx;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    always_comb begin
      bank_we[l]    = 1'b0;
      bank_wdata[l] = 8'h00;
      if (state == INIT) begin
        bank_we[l] = 1'b1;
      end else begin
        bank_we[l] = acc & req_we & ~err & be[l];
        case (req_funct3[1:0])
          2'b00:   bank_wdata[l] = req_wdata[7:0];
          2'b01:   bank_wdata[l] = req_wdata[8*(l%2) +: 8];
          default: bank_wdata[l] = req_wdata[8*l +: 8];
        endcase
      end
    end

    data_mem_bank #(.IDX_W(IDX_W)) u_bank (
      .clk   (clk),
      .we    (bank_we[l]),
      .waddr (bank_waddr),
      .wdata (bank_wdata[l]),
      .raddr (idx),
      .rdata (rd_word[l])
    );
  end

  // Load extraction and extension
  assign word   = rd_word;
  assign byte_v = word[8*lane +: 8];
  assign half_v = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = 32'h0;
    if (!req_we && !err) begin
      case (req_funct3)
        3'b000:  ld_data = {{24{byte_v[7]}}, byte_v};
        3'b001:  ld_data = {{16{half_v[15]}}, half_v};
        3'b010:  ld_data = word;
        3'b100:  ld_data = {24'h0, byte_v};
        3'b101:  ld_data = {16'h0, half_v};
        default: ld_data = 32'h0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      fill_cnt  <= '0;
      req_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == IDX_W'(DEPTH_WORDS - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        default: begin
          req_ready <= 1'b1;
          init_done <= 1'b1;
        end
      endcase
    end
  end

  // Idle stages carry zeros so the outputs read 0 outside response cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int i = 1; i <= READ_LATENCY; i++) dat_pipe[i] <= 32'h0;
    end else begin
      vld_pipe[1] <= acc;
      err_pipe[1] <= acc & err;
      dat_pipe[1] <= acc ? ld_data : 32'h0;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        err_pipe[i] <= err_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  assign resp_valid = vld_pipe[READ_LATENCY];
  assign resp_err   = err_pipe[READ_LATENCY];
  assign resp_rdata = dat_pipe[READ_LATENCY];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench: two instances (latency 1 and 3) driven with identical requests.

module tb_data_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rdy1, rv1, re1, done1;
  logic [31:0] rd1;
  logic        rdy3, rv3, re3, done3;
  logic [31:0] rd3;
  int          nvec = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(64), .READ_LATENCY(1), .ADDR_WIDTH(32)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_err(re1), .init_done(done1));

  data_mem_ctrl #(.DEPTH_WORDS(64), .READ_LATENCY(3), .ADDR_WIDTH(32)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy3), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(re3), .init_done(done3));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One isolated request; latency-1 copy checked after the accept edge, latency-3 two edges later
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
    chk({tag, ".v1"}, 32'(rv1), 32'd1);
    chk({tag, ".d1"}, rd1, exp_rd);
    chk({tag, ".e1"}, 32'(re1), 32'(exp_err));
    chk({tag, ".v3early"}, 32'(rv3), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v1idle"}, 32'(rv1), 32'd0);
    chk({tag, ".v3early2"}, 32'(rv3), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".v3"}, 32'(rv3), 32'd1);
    chk({tag, ".d3"}, rd3, exp_rd);
    chk({tag, ".e3"}, 32'(re3), 32'(exp_err));
  endtask

  // Counts edges from reset release until both copies raise req_ready
  task automatic wait_init(input string tag, input logic poke);
    int   cnt;
    logic seen_resp;
    cnt = 0;
    seen_resp = 1'b0;
    if (poke) begin
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
    end
    while (!(rdy1 && rdy3) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
      if (rv1 || rv3) seen_resp = 1'b1;
    end
    req_valid = 1'b0; req_we = 1'b0;
    chk({tag, ".cycles"}, 32'(cnt), 32'd64);
    chk({tag, ".rdy_same"}, 32'(rdy3), 32'(rdy1));
    chk({tag, ".done1"}, 32'(done1), 32'd1);
    chk({tag, ".done3"}, 32'(done3), 32'd1);
    chk({tag, ".no_resp"}, 32'(seen_resp), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout got none exp summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.rdy1", 32'(rdy1), 32'd0);
    chk("rst.rdy3", 32'(rdy3), 32'd0);
    chk("rst.v1", 32'(rv1), 32'd0);
    chk("rst.v3", 32'(rv3), 32'd0);
    chk("rst.d1", rd1, 32'h0);
    chk("rst.e1", 32'(re1), 32'd0);
    chk("rst.done1", 32'(done1), 32'd0);
    chk("rst.done3", 32'(done3), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("init", 1'b1);

    for (int a = 0; a < 64; a++)
      do_req($sformatf("zero%0d", a), 1'b0, 3'b010, 32'(4*a), 32'h0, 32'h0, 1'b0);

    // Sizes and sign extension
    do_req("sw0",   1'b1, 3'b010, 32'h0, 32'h8081_7F80, 32'h0, 1'b0);
    do_req("lb0",   1'b0, 3'b000, 32'h0, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_req("lbu0",  1'b0, 3'b100, 32'h0, 32'h0, 32'h0000_0080, 1'b0);
    do_req("lb1",   1'b0, 3'b000, 32'h1, 32'h0, 32'h0000_007F, 1'b0);
    do_req("lb3",   1'b0, 3'b000, 32'h3, 32'h0, 32'hFFFF_FF80, 1'b0);
    do_req("lh2",   1'b0, 3'b001, 32'h2, 32'h0, 32'hFFFF_8081, 1'b0);
    do_req("lhu2",  1'b0, 3'b101, 32'h2, 32'h0, 32'h0000_8081, 1'b0);
    do_req("lhu0",  1'b0, 3'b101, 32'h0, 32'h0, 32'h0000_7F80, 1'b0);

    // Partial stores
    do_req("sw10",  1'b1, 3'b010, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b0);
    do_req("sb12",  1'b1, 3'b000, 32'h12, 32'h0000_0000, 32'h0, 1'b0);
    do_req("sh10",  1'b1, 3'b001, 32'h10, 32'hAB12_1234, 32'h0, 1'b0);
    do_req("lw10",  1'b0, 3'b010, 32'h10, 32'h0, 32'hFF00_1234, 1'b0);
    do_req("sb13",  1'b1, 3'b000, 32'h13, 32'h0000_005A, 32'h0, 1'b0);
    do_req("lw10b", 1'b0, 3'b010, 32'h10, 32'h0, 32'h5A00_1234, 1'b0);

    // Errors
    do_req("lw6",   1'b0, 3'b010, 32'h6,   32'h0, 32'h0, 1'b1);
    do_req("sh3",   1'b1, 3'b001, 32'h3,   32'h0000_AAAA, 32'h0, 1'b1);
    do_req("lh1",   1'b0, 3'b001, 32'h1,   32'h0, 32'h0, 1'b1);
    do_req("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 32'h0, 1'b1);
    do_req("sb100", 1'b1, 3'b000, 32'h100, 32'h0000_0011, 32'h0, 1'b1);
    do_req("f3_011",1'b0, 3'b011, 32'h0,   32'h0, 32'h0, 1'b1);
    do_req("f3_110",1'b0, 3'b110, 32'h0,   32'h0, 32'h0, 1'b1);
    do_req("st_100",1'b1, 3'b100, 32'h0,   32'h0000_0000, 32'h0, 1'b1);
    do_req("lw0chk",1'b0, 3'b010, 32'h0,   32'h0, 32'h8081_7F80, 1'b0);

    // Back-to-back loads
    do_req("pre0", 1'b1, 3'b010, 32'h0, 32'd1, 32'h0, 1'b0);
    do_req("pre4", 1'b1, 3'b010, 32'h4, 32'd2, 32'h0, 1'b0);
    do_req("pre8", 1'b1, 3'b010, 32'h8, 32'd3, 32'h0, 1'b0);
    do_req("preC", 1'b1, 3'b010, 32'hC, 32'd4, 32'h0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 4) begin
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'(4*k);
      end else req_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("b2b%0d.v1", k), 32'(rv1), (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("b2b%0d.d1", k), rd1, (k < 4) ? 32'(k+1) : 32'd0);
      chk($sformatf("b2b%0d.v3", k), 32'(rv3), (k >= 2 && k < 6) ? 32'd1 : 32'd0);
      chk($sformatf("b2b%0d.d3", k), rd3, (k >= 2 && k < 6) ? 32'(k-1) : 32'd0);
    end

    // Store immediately followed by a load of the same word
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = (k < 2); req_we = (k == 0); req_funct3 = 3'b010;
      req_addr = 32'h20; req_wdata = 32'hCAFE_F00D;
      @(posedge clk); #1;
      chk($sformatf("raw%0d.v1", k), 32'(rv1), (k < 2) ? 32'd1 : 32'd0);
      chk($sformatf("raw%0d.d1", k), rd1, (k == 1) ? 32'hCAFE_F00D : 32'h0);
      chk($sformatf("raw%0d.v3", k), 32'(rv3), (k == 2 || k == 3) ? 32'd1 : 32'd0);
      chk($sformatf("raw%0d.d3", k), rd3, (k == 3) ? 32'hCAFE_F00D : 32'h0);
    end
    req_valid = 1'b0; req_we = 1'b0;

    // Reset with two responses still in flight in the latency-3 copy
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'(4*k);
      @(posedge clk); #1;
      chk($sformatf("mid%0d.v1", k), 32'(rv1), 32'd1);
      chk($sformatf("mid%0d.v3", k), 32'(rv3), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid.rst.v1", 32'(rv1), 32'd0);
    chk("mid.rst.rdy1", 32'(rdy1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mid.hold%0d.v3", k), 32'(rv3), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    wait_init("reinit", 1'b0);
    do_req("post.lw0",  1'b0, 3'b010, 32'h0,  32'h0, 32'h0, 1'b0);
    do_req("post.lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 1'b0);
    do_req("post.lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
